// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode values, MIPS field positions and the
// program loader state encoding. The control decoder reuses the opcodes.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_SLI   = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_LW    = 6'd4;
    localparam logic [5:0] OP_SW    = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd6;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into a 32-bit MIPS-format word and
// flags opcodes outside the supported set.
module instr_encoder
    import isa_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the R, I or J layout by opcode; unused fields stay zero.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[OP_MSB:OP_LSB] = opcode;
        case (opcode)
            OP_RTYPE: begin
                word[RS_MSB:RS_LSB]       = rs;
                word[RT_MSB:RT_LSB]       = rt;
                word[RD_MSB:RD_LSB]       = rd;
                word[SHAMT_MSB:SHAMT_LSB] = 5'd0;
                word[FUNCT_MSB:FUNCT_LSB] = funct;
            end
            OP_SLI, OP_LW, OP_SW, OP_ADDI: begin
                word[RS_MSB:RS_LSB]   = rs;
                word[RT_MSB:RT_LSB]   = rt;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            OP_J, OP_JAL: begin
                word[TARGET_MSB:TARGET_LSB] = target;
            end
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts field bundles, encodes them and writes them to
// consecutive instruction-memory addresses starting at PROG_BASE.
module prog_loader
    import isa_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int PROG_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              fld_valid,
    output logic              fld_ready,
    input  logic [5:0]        fld_opcode,
    input  logic [4:0]        fld_rs,
    input  logic [4:0]        fld_rt,
    input  logic [4:0]        fld_rd,
    input  logic [5:0]        fld_funct,
    input  logic [15:0]       fld_imm,
    input  logic [25:0]       fld_target,
    input  logic              fld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PROG_BASE);
    localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     state_q;
    loader_state_t     state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              last_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              done_q;
    logic              err_illegal_q;
    logic              err_full_q;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              start_ok;
    logic              fire;
    logic              at_end;

    instr_encoder u_encoder (
        .opcode  (fld_opcode),
        .rs      (fld_rs),
        .rt      (fld_rt),
        .rd      (fld_rd),
        .funct   (fld_funct),
        .imm     (fld_imm),
        .target  (fld_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign at_end = (addr_q == END_ADDR);

    // State register; reset returns to IDLE so imem_we falls at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the strobes that depend only on the current state.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        fire      = 1'b0;
        fld_ready = 1'b0;
        imem_we   = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                fld_ready = 1'b1;
                busy      = 1'b1;
                if (fld_valid) begin
                    fire    = 1'b1;
                    state_d = enc_illegal ? ST_ERROR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (at_end) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address, count, captured word and sticky status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= BASE_ADDR;
            count_q       <= '0;
            last_q        <= 1'b0;
            wdata_q       <= '0;
            waddr_q       <= '0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_q        <= BASE_ADDR;
                count_q       <= '0;
                done_q        <= 1'b0;
                err_illegal_q <= 1'b0;
                err_full_q    <= 1'b0;
            end
            if (fire && !enc_illegal) begin
                wdata_q <= enc_word;
                waddr_q <= addr_q;
                last_q  <= fld_last;
            end
            if (fire && enc_illegal) begin
                err_illegal_q <= 1'b1;
            end
            if (state_q == ST_WRITE) begin
                count_q <= count_q + COUNT_ONE;
                if (last_q) begin
                    done_q <= 1'b1;
                end else if (at_end) begin
                    err_full_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + ADDR_ONE;
                end
            end
        end
    end

    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign done        = done_q;
    assign err_illegal = err_illegal_q;
    assign err_full    = err_full_q;
    assign count       = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random and directed bundles are
// compared against a queue of expected memory writes and session flags.
module tb_prog_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              fld_valid = 1'b0;
    logic              fld_ready;
    logic [5:0]        fld_opcode = '0;
    logic [4:0]        fld_rs = '0;
    logic [4:0]        fld_rt = '0;
    logic [4:0]        fld_rd = '0;
    logic [5:0]        fld_funct = '0;
    logic [15:0]       fld_imm = '0;
    logic [25:0]       fld_target = '0;
    logic              fld_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_full;
    logic [ADDR_W:0]   count;

    logic        s4_start = 1'b0;
    logic        s4_fld_valid = 1'b0;
    logic        s4_fld_ready;
    logic        s4_imem_we;
    logic [1:0]  s4_imem_addr;
    logic [31:0] s4_imem_wdata;
    logic        s4_busy;
    logic        s4_done;
    logic        s4_err_illegal;
    logic        s4_err_full;
    logic [2:0]  s4_count;

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PROG_BASE(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .fld_valid(fld_valid), .fld_ready(fld_ready),
        .fld_opcode(fld_opcode), .fld_rs(fld_rs), .fld_rt(fld_rt),
        .fld_rd(fld_rd), .fld_funct(fld_funct), .fld_imm(fld_imm),
        .fld_target(fld_target), .fld_last(fld_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal),
        .err_full(err_full), .count(count)
    );

    prog_loader #(.DEPTH(4), .ADDR_W(2), .PROG_BASE(0)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(s4_start),
        .fld_valid(s4_fld_valid), .fld_ready(s4_fld_ready),
        .fld_opcode(fld_opcode), .fld_rs(fld_rs), .fld_rt(fld_rt),
        .fld_rd(fld_rd), .fld_funct(fld_funct), .fld_imm(fld_imm),
        .fld_target(fld_target), .fld_last(fld_last),
        .imem_we(s4_imem_we), .imem_addr(s4_imem_addr),
        .imem_wdata(s4_imem_wdata), .busy(s4_busy), .done(s4_done),
        .err_illegal(s4_err_illegal), .err_full(s4_err_full),
        .count(s4_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned op;
        int unsigned rs;
        int unsigned rt;
        int unsigned rd;
        int unsigned funct;
        int unsigned imm;
        int unsigned target;
        bit          last;
    } bundle_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] word;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          writes_seen = 0;
    int          m_total = 0;
    int unsigned m_addr = 0;
    int unsigned m_count = 0;
    bit          m_done = 1'b0;
    bit          m_illegal = 1'b0;
    bit          m_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelEncode(input bundle_t b);
        int unsigned w;
        if (b.op == 0)
            w = b.rs * (1 << 21) + b.rt * (1 << 16) + b.rd * (1 << 11) + b.funct;
        else if (b.op == 2 || b.op == 3)
            w = b.op * (1 << 26) + b.target;
        else
            w = b.op * (1 << 26) + b.rs * (1 << 21) + b.rt * (1 << 16) + b.imm;
        return w;
    endfunction

    function automatic bundle_t mk(input int unsigned op, rs, rt, rd, funct, imm, target,
                                   input bit last);
        bundle_t b;
        b.op = op; b.rs = rs; b.rt = rt; b.rd = rd; b.funct = funct;
        b.imm = imm; b.target = target; b.last = last;
        return b;
    endfunction

    function automatic bundle_t randBundle(input bit legal, input bit last);
        return mk(legal ? $urandom_range(0, 6) : $urandom_range(7, 63),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 63), $urandom_range(0, 65535),
                  $urandom % (1 << 26), last);
    endfunction

    // Model of one accepted bundle: queue the write and advance the session.
    function automatic void modelAccept(input bundle_t b);
        wr_t e;
        if (b.op > 6) begin
            m_illegal = 1'b1;
        end else begin
            e.addr = m_addr;
            e.word = modelEncode(b);
            exp_q.push_back(e);
            m_total++;
            m_count++;
            if (b.last) m_done = 1'b1;
            else if (m_addr == DEPTH - 1) m_full = 1'b1;
            else m_addr++;
        end
    endfunction

    function automatic void modelStart();
        m_addr = 0; m_count = 0;
        m_done = 1'b0; m_illegal = 1'b0; m_full = 1'b0;
    endfunction

    task automatic driveBundle(input bundle_t b);
        fld_opcode = 6'(b.op);
        fld_rs     = 5'(b.rs);
        fld_rt     = 5'(b.rt);
        fld_rd     = 5'(b.rd);
        fld_funct  = 6'(b.funct);
        fld_imm    = 16'(b.imm);
        fld_target = 26'(b.target);
        fld_last   = b.last;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a bundle with valid high until it is taken or the budget expires.
    task automatic applyStimulus(input bundle_t b, input int budget,
                                 output bit accepted, output int hs_cycle);
        driveBundle(b);
        fld_valid = 1'b1;
        accepted  = 1'b0;
        hs_cycle  = -1;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (fld_ready === 1'b1) begin
                accepted = 1'b1;
                hs_cycle = cyc;
                modelAccept(b);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart(input bit honoured);
        start = 1'b1;
        settle(1);
        start = 1'b0;
        if (honoured) modelStart();
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_done"}, 32'(done), 32'(m_done));
        checkOutput({tag, "_err_illegal"}, 32'(err_illegal), 32'(m_illegal));
        checkOutput({tag, "_err_full"}, 32'(err_full), 32'(m_full));
        checkOutput({tag, "_count"}, 32'(count), m_count);
        checkOutput({tag, "_writes"}, writes_seen, m_total);
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            writes_seen++;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("write_addr", 32'(imem_addr), mon_e.addr);
                checkOutput("write_data", imem_wdata, mon_e.word);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit      acc;
        int      hs0, hs1, hs2;
        bundle_t b;
        int      hs4, wr4;

        // Reset state
        settle(2);
        checkOutput("rst_we", 32'(imem_we), 0);
        checkOutput("rst_ready", 32'(fld_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_addr", 32'(imem_addr), 0);
        checkOutput("rst_wdata", imem_wdata, 0);
        reset_n = 1'b1;
        settle(1);
        checkOutput("idle_ready", 32'(fld_ready), 0);

        // Single R-type program
        pulseStart(1);
        checkOutput("accept_ready", 32'(fld_ready), 1);
        checkOutput("accept_busy", 32'(busy), 1);
        applyStimulus(mk(0, 1, 2, 3, 'h20, 0, 0, 1), 10, acc, hs0);
        checkOutput("rtype_accept", 32'(acc), 1);
        fld_valid = 1'b0;
        settle(1);
        checkFlags("rtype");
        checkOutput("rtype_word", imem_wdata, 32'h0022_1820);

        // Back-to-back addi, lw, j with valid held high
        pulseStart(1);
        applyStimulus(mk(6, 1, 2, 0, 0, 5, 0, 0), 10, acc, hs0);
        applyStimulus(mk(4, 0, 8, 0, 0, 'hFFFC, 0, 0), 10, acc, hs1);
        applyStimulus(mk(2, 0, 0, 0, 0, 0, 'h10, 1), 10, acc, hs2);
        fld_valid = 1'b0;
        checkOutput("b2b_gap1", hs1 - hs0, 2);
        checkOutput("b2b_gap2", hs2 - hs1, 2);
        settle(1);
        checkFlags("b2b");
        checkOutput("b2b_last_word", imem_wdata, 32'h0800_0010);
        checkOutput("b2b_last_addr", 32'(imem_addr), 2);

        // Illegal opcode after one valid word
        pulseStart(1);
        applyStimulus(randBundle(1, 0), 10, acc, hs0);
        applyStimulus(randBundle(0, 0), 10, acc, hs0);
        checkOutput("illegal_accept", 32'(acc), 1);
        fld_valid = 1'b0;
        settle(2);
        checkFlags("illegal");
        checkOutput("illegal_ready", 32'(fld_ready), 0);
        pulseStart(1);
        checkOutput("restart_err_clear", 32'(err_illegal), 0);
        applyStimulus(randBundle(1, 1), 10, acc, hs0);
        fld_valid = 1'b0;
        settle(1);
        checkFlags("restart");

        // Start during ACCEPT is ignored
        pulseStart(1);
        applyStimulus(randBundle(1, 0), 10, acc, hs0);
        fld_valid = 1'b0;
        settle(1);
        pulseStart(0);
        checkOutput("ign_count", 32'(count), 1);
        checkOutput("ign_ready", 32'(fld_ready), 1);
        applyStimulus(randBundle(1, 1), 10, acc, hs0);
        fld_valid = 1'b0;
        settle(1);
        checkFlags("ign");
        checkOutput("ign_addr", 32'(imem_addr), 1);

        // Random sessions with random valid gaps
        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, 15);
            pulseStart(1);
            for (int k = 0; k < n; k++) begin
                applyStimulus(randBundle(1, k == n - 1), 10, acc, hs0);
                checkOutput("rnd_accept", 32'(acc), 1);
                if ($urandom_range(0, 1) == 1) begin
                    fld_valid = 1'b0;
                    settle($urandom_range(1, 3));
                end
            end
            fld_valid = 1'b0;
            settle(2);
            checkFlags("rnd");
        end

        // Fill the whole memory without fld_last
        pulseStart(1);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(randBundle(1, 0), 10, acc, hs0);
        end
        applyStimulus(randBundle(1, 0), 6, acc, hs0);
        checkOutput("full_extra_refused", 32'(acc), 0);
        fld_valid = 1'b0;
        settle(1);
        checkFlags("full");
        checkOutput("full_ready", 32'(fld_ready), 0);

        // Reset asserted in the middle of the WRITE cycle
        pulseStart(1);
        applyStimulus(randBundle(1, 1), 10, acc, hs0);
        fld_valid = 1'b0;
        checkOutput("mid_we_high", 32'(imem_we), 1);
        void'(exp_q.pop_back());
        m_total--;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", 32'(imem_we), 0);
        checkOutput("mid_rst_wdata", imem_wdata, 0);
        checkOutput("mid_rst_addr", 32'(imem_addr), 0);
        checkOutput("mid_rst_count", 32'(count), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        modelStart();
        settle(2);
        checkOutput("post_rst_ready", 32'(fld_ready), 0);
        checkFlags("post_rst");

        // Four-word instance overflows after address 3
        b = randBundle(1, 0);
        driveBundle(b);
        s4_start = 1'b1;
        settle(1);
        s4_start = 1'b0;
        s4_fld_valid = 1'b1;
        hs4 = 0;
        wr4 = 0;
        repeat (20) begin
            @(negedge clk);
            if (s4_fld_ready === 1'b1) hs4++;
            if (s4_imem_we === 1'b1) begin
                checkOutput("s4_addr", 32'(s4_imem_addr), wr4);
                checkOutput("s4_data", s4_imem_wdata, modelEncode(b));
                wr4++;
            end
        end
        s4_fld_valid = 1'b0;
        checkOutput("s4_handshakes", hs4, 4);
        checkOutput("s4_writes", wr4, 4);
        checkOutput("s4_err_full", 32'(s4_err_full), 1);
        checkOutput("s4_count", 32'(s4_count), 4);
        checkOutput("s4_done", 32'(s4_done), 0);
        checkOutput("s4_err_illegal", 32'(s4_err_illegal), 0);
        checkOutput("s4_busy", 32'(s4_busy), 0);

        checkOutput("writes_total", writes_seen, m_total);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
